peak_detect: RTL and testbench
==============================

PEAK_DETECT -- requirements
Module: peak_detect

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the datain and value width in bits.
REQ-002 The block SHALL have parameter CNTW, default 16, giving the period counter width in bits.
REQ-003 The block SHALL have parameter HYST, default 2, giving the consecutive samples needed to confirm a direction change; it SHALL be used only when PEAK_DETECT_HYST_EN is defined.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port en, input, 1 bit: sample enable; one sample per cycle while high.
REQ-007 The block SHALL have port datain, input, WIDTH bits: two's-complement sample, aligned with eq/lt/gt in the same cycle.
REQ-008 The block SHALL have ports eq, lt and gt, input, 1 bit each, from the upstream slope stage: datain equal to, less than, or greater than the previous sample.
REQ-009 The block SHALL have port peak, output, 1 bit: one-cycle pulse marking a detected local maximum.
REQ-010 The block SHALL have port trough, output, 1 bit: one-cycle pulse marking a detected local minimum.
REQ-011 The block SHALL have port peak_val, output, WIDTH bits: value of the last detected maximum.
REQ-012 The block SHALL have port trough_val, output, WIDTH bits: value of the last detected minimum.
REQ-013 The block SHALL have port period, output, CNTW bits: en-cycles between the last two peaks.
REQ-014 The block SHALL have port period_valid, output, 1 bit: one-cycle pulse, coincident with peak, when period is updated.

Function
REQ-015 The block SHALL hold d_prev, which takes the value of datain on every en-high cycle.
REQ-016 The block SHALL implement FSM states IDLE, RISING and FALLING; IDLE SHALL go to RISING on gt and to FALLING on lt, with no pulse.
REQ-017 In RISING, the block SHALL go to FALLING on lt, assert peak and load peak_val with d_prev.
REQ-018 In FALLING, the block SHALL go to RISING on gt, assert trough and load trough_val with d_prev.
REQ-019 The block SHALL treat eq, and any cycle with lt and gt both high, as no change: hold state, no pulse.
REQ-020 Peak and trough pulses SHALL be registered and appear one cycle after the input cycle that caused them; peak_val, trough_val and period SHALL update in the same cycle as their pulse.
REQ-021 The period counter SHALL increment on every en-high cycle and saturate at 2^CNTW-1 without wrapping.
REQ-022 On a peak, period SHALL be loaded with the counter value including the peak cycle, and the counter SHALL restart at 1.
REQ-023 period_valid SHALL be suppressed on the first peak after reset and asserted on every later peak.
REQ-024 While en is low, all state SHALL hold, peak, trough and period_valid SHALL be 0, and the inputs SHALL be ignored.
REQ-025 The upstream slope flags for the first sample after reset are undefined; the block SHALL ignore the eq/lt/gt flags on the first en-high cycle after reset.

Reset
REQ-026 On reset high at a clock edge, the state SHALL become IDLE and d_prev, peak_val, trough_val, period and the counter SHALL become 0.
REQ-027 On reset, peak, trough and period_valid SHALL be 0 and the first-peak flag SHALL be set.
REQ-028 Reset SHALL take priority over en and SHALL abort any transition or hysteresis run in progress.

Configuration
REQ-029 With macro PEAK_DETECT_HYST_EN defined, a RISING-to-FALLING or FALLING-to-RISING transition SHALL require HYST consecutive en-cycles of the opposite flag; any other flag SHALL clear the run.
REQ-030 With PEAK_DETECT_HYST_EN defined, the candidate extreme SHALL be d_prev at the first cycle of the run, and the pulse SHALL come one cycle after the HYST-th cycle.
REQ-031 With PEAK_DETECT_HYST_EN undefined, transitions SHALL be immediate as in REQ-017/REQ-018, HYST SHALL be ignored, and no run logic SHALL be synthesised.

Verification
REQ-032 Bench SHALL cover: reset, then en=1 with samples 0,1,2,3,2,1 -> peak pulse one cycle after sample 2 (second), with peak_val=3 and period_valid=0.
REQ-033 Bench SHALL cover: triangle wave of period 8 samples, amplitude +/-4 -> trough_val=0xFFFC (-4), peak_val=4, period=8 with period_valid from the second peak on.
REQ-034 Bench SHALL cover: en toggling 1,0,1,0 during a rising ramp -> state and counter frozen on en=0 cycles; period counts only en=1 cycles.
REQ-035 Bench SHALL cover: lt and gt both high, and eq held for 5 cycles in RISING -> no state change, no pulse, counter +5.
REQ-036 Bench SHALL cover: CNTW=4 with no peak for 20 cycles -> next period=15 (saturated).
REQ-037 Bench SHALL cover, with PEAK_DETECT_HYST_EN and HYST=2: single-sample dip 5,6,5,7 -> no peak; then 7,6,5 -> peak with peak_val=7.

Source files
------------

// File: rtl/peak_detect.sv
// peak_detect: slope-driven local max/min detector with a peak-to-peak period counter.
// Define PEAK_DETECT_HYST_EN to require HYST consecutive opposite-slope samples before a turn.
module peak_detect #(
   parameter int WIDTH = 16,
   parameter int CNTW  = 16,
   parameter int HYST  = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] datain,
   input  logic                    eq,
   input  logic                    lt,
   input  logic                    gt,
   output logic                    peak,
   output logic                    trough,
   output logic signed [WIDTH-1:0] peak_val,
   output logic signed [WIDTH-1:0] trough_val,
   output logic        [CNTW-1:0]  period,
   output logic                    period_valid
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RISING  = 2'd1,
      FALLING = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    first_q, first_peak_q;
   logic signed [WIDTH-1:0] d_prev_q;
   logic signed [WIDTH-1:0] peak_val_q, peak_val_d;
   logic signed [WIDTH-1:0] trough_val_q, trough_val_d;
   logic        [CNTW-1:0]  cnt_q, cnt_d;
   logic        [CNTW-1:0]  period_q, period_d;
   logic                    peak_q, peak_d;
   logic                    trough_q, trough_d;
   logic                    pv_q, pv_d;
   logic                    up_w, dn_w, turn_w, confirm_w;
   logic signed [WIDTH-1:0] extreme_w;

   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + CNTW'(1);
   endfunction

   // Slope flags of the first sample after reset compare against nothing real.
   assign up_w   = en & ~first_q & gt & ~lt & ~eq;
   assign dn_w   = en & ~first_q & lt & ~gt & ~eq;
   assign turn_w = ((state_q == RISING) & dn_w) | ((state_q == FALLING) & up_w);

`ifdef PEAK_DETECT_HYST_EN
   localparam int RUNW = (HYST < 2) ? 1 : $clog2(HYST);

   logic [RUNW-1:0]         run_q, run_d;
   logic signed [WIDTH-1:0] cand_q, cand_d;

   // The extreme is the sample just before the run started, not the one before confirmation.
   assign confirm_w = turn_w & (run_q == RUNW'(HYST - 1));
   assign extreme_w = (run_q == '0) ? d_prev_q : cand_q;

   always_comb begin
      run_d  = run_q;
      cand_d = cand_q;
      if (en) begin
         if (!turn_w || confirm_w) run_d = '0;
         else                      run_d = run_q + RUNW'(1);
         if (turn_w && (run_q == '0)) cand_d = d_prev_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) run_q <= '0;
      else       run_q <= run_d;
   end

   always_ff @(posedge clk) begin
      cand_q <= cand_d;
   end
`else
   assign confirm_w = turn_w;
   assign extreme_w = d_prev_q;

   // HYST has no effect in this build.
   if (HYST < 1) begin : g_hyst_unused
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (up_w)      state_d = RISING;
            else if (dn_w) state_d = FALLING;
         end
         RISING:  if (confirm_w) state_d = FALLING;
         FALLING: if (confirm_w) state_d = RISING;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      peak_d       = confirm_w & (state_q == RISING);
      trough_d     = confirm_w & (state_q == FALLING);
      pv_d         = peak_d & ~first_peak_q;
      peak_val_d   = peak_d ? extreme_w : peak_val_q;
      trough_val_d = trough_d ? extreme_w : trough_val_q;
      cnt_d        = cnt_q;
      period_d     = period_q;
      // Period includes the peak cycle itself; the next interval starts counting after it.
      if (en) begin
         cnt_d = peak_d ? '0 : sat_inc(cnt_q);
         if (peak_d) period_d = sat_inc(cnt_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         first_q      <= 1'b1;
         first_peak_q <= 1'b1;
         peak_q       <= 1'b0;
         trough_q     <= 1'b0;
         pv_q         <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (en)     first_q      <= 1'b0;
         if (peak_d) first_peak_q <= 1'b0;
         peak_q   <= peak_d;
         trough_q <= trough_d;
         pv_q     <= pv_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         d_prev_q     <= '0;
         peak_val_q   <= '0;
         trough_val_q <= '0;
         period_q     <= '0;
      end else begin
         if (en) d_prev_q <= datain;
         peak_val_q   <= peak_val_d;
         trough_val_q <= trough_val_d;
         period_q     <= period_d;
      end
   end

   assign peak         = peak_q;
   assign trough       = trough_q;
   assign peak_val     = peak_val_q;
   assign trough_val   = trough_val_q;
   assign period       = period_q;
   assign period_valid = pv_q;

endmodule

// File: tb/tb_peak_detect.sv
// Bench for peak_detect: directed scenarios plus a random walk, checked against a reference model.
// Two instances share stimulus: default widths and a 4-bit period counter for saturation.
module tb_peak_detect;

`ifdef PEAK_DETECT_HYST_EN
   localparam int HYST_M = 2;
`else
   localparam int HYST_M = 1;
`endif

   logic clk = 1'b0;
   logic reset, en, eq, lt, gt;
   logic signed [15:0] datain;
   logic peak, trough, pv, s_peak, s_trough, s_pv;
   logic signed [15:0] pval, tval, s_pval, s_tval;
   logic [15:0] per;
   logic [3:0]  s_per;

   always #5 clk = ~clk;

   peak_detect #(.WIDTH(16), .CNTW(16), .HYST(2)) u_dut (
      .clk(clk), .reset(reset), .en(en), .datain(datain), .eq(eq), .lt(lt), .gt(gt),
      .peak(peak), .trough(trough), .peak_val(pval), .trough_val(tval),
      .period(per), .period_valid(pv));

   peak_detect #(.WIDTH(16), .CNTW(4), .HYST(2)) u_sat (
      .clk(clk), .reset(reset), .en(en), .datain(datain), .eq(eq), .lt(lt), .gt(gt),
      .peak(s_peak), .trough(s_trough), .peak_val(s_pval), .trough_val(s_tval),
      .period(s_per), .period_valid(s_pv));

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: direction of travel, pending opposite-slope run, held results.
   int                 m_dir, m_run, m_en_cnt, m_last_pk, m_per16, m_per4;
   bit                 m_first, m_first_peak, e_peak, e_trough, e_pv;
   logic signed [15:0] m_prev, m_cand, m_pval, m_tval;
   logic signed [15:0] b_last;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      check({ph, ".peak"},     peak,     e_peak);
      check({ph, ".trough"},   trough,   e_trough);
      check({ph, ".pvalid"},   pv,       e_pv);
      check({ph, ".pval"},     pval,     m_pval);
      check({ph, ".tval"},     tval,     m_tval);
      check({ph, ".period"},   per,      m_per16);
      check({ph, ".s_peak"},   s_peak,   e_peak);
      check({ph, ".s_trough"}, s_trough, e_trough);
      check({ph, ".s_pvalid"}, s_pv,     e_pv);
      check({ph, ".s_pval"},   s_pval,   m_pval);
      check({ph, ".s_tval"},   s_tval,   m_tval);
      check({ph, ".s_period"}, s_per,    m_per4);
   endtask

   task automatic model_reset();
      m_dir = 0; m_run = 0; m_en_cnt = 0; m_last_pk = 0; m_per16 = 0; m_per4 = 0;
      m_first = 1'b1; m_first_peak = 1'b1;
      e_peak = 1'b0; e_trough = 1'b0; e_pv = 1'b0;
      m_prev = '0; m_cand = '0; m_pval = '0; m_tval = '0;
   endtask

   task automatic model_step(input bit e, input logic signed [15:0] d,
                             input bit fq, input bit fl, input bit fg);
      bit up, dn, turn;
      int span;
      e_peak = 1'b0; e_trough = 1'b0; e_pv = 1'b0;
      if (!e) return;
      m_en_cnt++;
      up = fg && !fl && !fq;
      dn = fl && !fg && !fq;
      if (m_first) begin
         up = 1'b0; dn = 1'b0; m_first = 1'b0;
      end
      turn = (m_dir == 1 && dn) || (m_dir == -1 && up);
      if (m_dir == 0) begin
         if (up)      m_dir = 1;
         else if (dn) m_dir = -1;
      end else if (turn) begin
         if (m_run == 0) m_cand = m_prev;
         m_run++;
         if (m_run == HYST_M) begin
            m_run = 0;
            if (m_dir == 1) begin
               e_peak = 1'b1;
               e_pv = !m_first_peak;
               m_first_peak = 1'b0;
               m_pval = m_cand;
               span = m_en_cnt - m_last_pk;
               m_per16 = (span > 65535) ? 65535 : span;
               m_per4  = (span > 15) ? 15 : span;
               m_last_pk = m_en_cnt;
            end else begin
               e_trough = 1'b1;
               m_tval = m_cand;
            end
            m_dir = -m_dir;
         end
      end else begin
         m_run = 0;
      end
      m_prev = d;
   endtask

   task automatic apply(input bit e, input logic signed [15:0] d,
                        input bit fq, input bit fl, input bit fg, input string ph);
      en = e; datain = d; eq = fq; lt = fl; gt = fg;
      model_step(e, d, fq, fl, fg);
      @(posedge clk);
      #1;
      check_all(ph);
   endtask

   // One enabled sample with slope flags derived from the previous enabled sample.
   task automatic samp(input logic signed [15:0] v, input string ph);
      logic signed [15:0] p;
      p = b_last;
      b_last = v;
      apply(1'b1, v, v == p, v < p, v > p, ph);
   endtask

   task automatic idle(input string ph);
      apply(1'b0, 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), ph);
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b1; datain = 16'sh1234; eq = 1'b0; lt = 1'b0; gt = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0; en = 1'b0;
      model_reset();
      b_last = '0;
      check_all("rst");
   endtask

   localparam logic signed [15:0] R32 [6] = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd2, 16'sd1};
   localparam logic signed [15:0] TRI [8] = '{16'sd0, 16'sd2, 16'sd4, 16'sd2,
                                              16'sd0, -16'sd2, -16'sd4, -16'sd2};
   localparam logic signed [15:0] R37 [9] = '{16'sd3, 16'sd4, 16'sd5, 16'sd6, 16'sd5,
                                              16'sd7, 16'sd7, 16'sd6, 16'sd5};

   initial begin
      int npk;
      model_reset();
      b_last = '0;
      do_reset();

      // Simple ramp up and back down.
      for (int i = 0; i < 6; i++) begin
         samp(R32[i], "ramp");
         if (i == 3 + HYST_M) begin
            check("ramp.peak_now", peak, 1);
            check("ramp.pvalid_now", pv, 0);
            check("ramp.pval_now", pval, 3);
         end
      end

      // Triangle, period 8, amplitude 4.
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int i = 0; i < 8; i++) samp(TRI[i], "tri");
      check("tri.pval_end", pval, 4);
      check("tri.tval_end", tval, -4);
      check("tri.period_end", per, 8);

      // Enable toggling on a ramp.
      do_reset();
      samp(16'sd0, "entog"); idle("entog");
      samp(16'sd1, "entog"); idle("entog");
      samp(16'sd2, "entog"); idle("entog");
      samp(16'sd3, "entog"); idle("entog");
      samp(16'sd2, "entog"); idle("entog");
      samp(16'sd1, "entog"); idle("entog");
      check("entog.period_end", per, 4 + HYST_M);

      // Both flags high, then eq held, while rising.
      do_reset();
      samp(16'sd0, "hold"); samp(16'sd1, "hold"); samp(16'sd2, "hold");
      b_last = 16'sd3;
      apply(1'b1, 16'sd3, 1'b0, 1'b1, 1'b1, "hold");
      for (int i = 0; i < 5; i++) samp(16'sd3, "hold");
      for (int k = 0; k < HYST_M; k++) samp(16'(2 - k), "hold");
      check("hold.period_end", per, 9 + HYST_M);
      check("hold.pval_end", pval, 3);

      // Long flat stretch saturates the 4-bit counter.
      do_reset();
      samp(16'sd0, "sat"); samp(16'sd1, "sat");
      for (int i = 0; i < 20; i++) samp(16'sd1, "sat");
      samp(16'sd0, "sat"); samp(-16'sd1, "sat");
      check("sat.s_period_end", s_per, 15);
      check("sat.period_end", per, 22 + HYST_M);

      // Single-sample dip, then a real turn.
      do_reset();
      npk = 0;
      for (int i = 0; i < 9; i++) begin
         samp(R37[i], "dip");
         if (peak) npk++;
      end
      check("dip.npeaks", npk, 3 - HYST_M);
      check("dip.pval_end", pval, 7);

      // Random walk with enable gaps, contradictory flags and a mid-run reset.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         int w;
         logic signed [15:0] v;
         if (i == 300) do_reset();
         w = int'(b_last) + int'($urandom_range(0, 6)) - 3;
         v = 16'(w);
         if ($urandom_range(0, 9) < 2) idle("rnd");
         else if ($urandom_range(0, 19) == 0) begin
            b_last = v;
            apply(1'b1, v, 1'b0, 1'b1, 1'b1, "rnd");
         end else samp(v, "rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
